uart_tx_scheduler: RTL

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_tx_scheduler.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_scheduler.sv
// Purpose : arbitrates ALU (2-byte) and register-file (1-byte) results onto a single UART transmitter.
// Latency : 2 cycles from a VLD pulse (idle FSM, empty slot) to the TX_D_VLD pulse; one byte in flight at a time.
// Backpr. : one pending slot per requester; a request to a full slot is dropped and flagged on sticky OVF.
module uart_tx_scheduler #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ALU_VLD,
    input  logic [15:0] ALU_OUT,
    input  logic        RF_VLD,
    input  logic [7:0]  RF_RD_DATA,
    input  logic        TX_BUSY,
    output logic [7:0]  TX_P_DATA,
    output logic        TX_D_VLD,
    output logic        SCHED_BUSY,
    output logic        OVF
);

    localparam int CW = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    state_t          state;

    // pending slots
    logic [15:0]     alu_dat;
    logic            alu_full;
    logic [7:0]      rf_dat;
    logic            rf_full;

    // transfer context
    logic            serve_rf;   // slot currently being transmitted (1 = RF)
    logic            byte_hi;    // ALU high byte is the one in flight
    logic            pri_rf;     // tie-break pointer, 1 = RF wins the next tie
    logic [CW-1:0]   wait_cnt;

    logic            byte_done;
    logic            alu_free;
    logic            rf_free;
    logic            tie;
    logic            pick_rf;

    // Slot release happens on the edge that ends the last byte of that slot.
    always_comb begin
        byte_done = (state == WAIT_LO) && !TX_BUSY;
        alu_free  = byte_done && !serve_rf && byte_hi;
        rf_free   = byte_done && serve_rf;
        tie       = alu_full && rf_full;
        pick_rf   = rf_full && (!alu_full || pri_rf);
    end

    assign SCHED_BUSY = alu_full || rf_full || (state != IDLE);

    // Capture requests into empty (or just-freed) slots; drop and flag otherwise.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            alu_dat  <= '0;
            alu_full <= 1'b0;
            rf_dat   <= '0;
            rf_full  <= 1'b0;
            OVF      <= 1'b0;
        end else begin
            if (ALU_VLD) begin
                if (!alu_full || alu_free) begin
                    alu_dat  <= ALU_OUT;
                    alu_full <= 1'b1;
                end
            end else if (alu_free) begin
                alu_full <= 1'b0;
            end

            if (RF_VLD) begin
                if (!rf_full || rf_free) begin
                    rf_dat  <= RF_RD_DATA;
                    rf_full <= 1'b1;
                end
            end else if (rf_free) begin
                rf_full <= 1'b0;
            end

            if ((ALU_VLD && alu_full && !alu_free) || (RF_VLD && rf_full && !rf_free)) begin
                OVF <= 1'b1;
            end
        end
    end

    // Transmit FSM: issue a byte, wait for BUSY to rise (re-issue on timeout), then for it to fall.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            TX_D_VLD  <= 1'b0;
            TX_P_DATA <= 8'h00;
            serve_rf  <= 1'b0;
            byte_hi   <= 1'b0;
            pri_rf    <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (alu_full || rf_full) begin
                        state     <= LOAD;
                        TX_D_VLD  <= 1'b1;
                        serve_rf  <= pick_rf;
                        byte_hi   <= 1'b0;
                        TX_P_DATA <= pick_rf ? rf_dat : alu_dat[7:0];
                        // pointer only moves when both slots competed
                        if (tie) begin
                            pri_rf <= !pick_rf;
                        end
                    end
                end
                LOAD: begin
                    state    <= WAIT_HI;
                    TX_D_VLD <= 1'b0;
                    wait_cnt <= '0;
                end
                WAIT_HI: begin
                    if (TX_BUSY) begin
                        state <= WAIT_LO;
                    end else if (wait_cnt == CW'(WAIT_LIMIT)) begin
                        // transmitter never acknowledged: re-issue the same byte
                        state    <= LOAD;
                        TX_D_VLD <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (!TX_BUSY) begin
                        if (!serve_rf && !byte_hi) begin
                            state     <= LOAD;
                            TX_D_VLD  <= 1'b1;
                            byte_hi   <= 1'b1;
                            TX_P_DATA <= alu_dat[15:8];
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    TX_D_VLD <= 1'b0;
                end
            endcase
        end
    end

endmodule
